// File: rtl/ksa_if.sv
// Handshake and single-port S-memory bus shared by the ARC4 KSA stage.
// slave: the KSA engine; master: the requester and S memory side.
interface ksa_if;
   localparam int unsigned KEY_W  = 24;
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 8;

   logic              en;
   logic              rdy;
   logic [KEY_W-1:0]  key;
   logic [ADDR_W-1:0] s_addr;
   logic [DATA_W-1:0] s_rddata;
   logic [DATA_W-1:0] s_wrdata;
   logic              s_wren;

   modport slave (
      input  en, key, s_rddata,
      output rdy, s_addr, s_wrdata, s_wren
   );

   modport master (
      output en, key, s_rddata,
      input  rdy, s_addr, s_wrdata, s_wren
   );
endinterface

// File: rtl/ksa.sv
// ARC4 key-scheduling pass over a shared 256x8 S memory, 4 cycles per index.
// Optional KSA_INIT_PASS_EN: prepend an S[c]=c init pass of 256 writes.
module ksa #(
   parameter int unsigned KEY_BYTES = 3
) (
   input  logic  clk,
   input  logic  rst_n,
   ksa_if.slave  bus
);
   localparam int unsigned AW = 8;
   localparam int unsigned KW = 24;
   localparam logic [1:0]  KIDX_LAST = 2'(KEY_BYTES - 1);
   localparam logic [AW-1:0] LAST_IDX = 8'hFF;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      INIT_WR = 3'd1,
      RD_I    = 3'd2,
      CALC_J  = 3'd3,
      WR_I    = 3'd4,
      WR_J    = 3'd5
   } state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   i_q, i_d;
   logic [AW-1:0]   j_q, j_d;
   logic [1:0]      kidx_q, kidx_d;
   logic [AW-1:0]   si_q, si_d;
   logic [KW-1:0]   key_q, key_d;
   // Low for the first cycle after reset release so rdy stays 0 during reset.
   logic            live_q;

   logic [AW-1:0]   kbyte;
   logic [AW-1:0]   jn;
   logic            rdy_c;
   logic [AW-1:0]   addr_c;
   logic [AW-1:0]   wrdata_c;
   logic            wren_c;

   always_comb begin
      unique case (kidx_q)
         2'd0:    kbyte = key_q[23:16];
         2'd1:    kbyte = key_q[15:8];
         default: kbyte = key_q[7:0];
      endcase
   end

   assign jn = j_q + bus.s_rddata + kbyte;

   // Next-state and combinational S-bus drive.
   always_comb begin
      state_d  = state_q;
      i_d      = i_q;
      j_d      = j_q;
      kidx_d   = kidx_q;
      si_d     = si_q;
      key_d    = key_q;
      rdy_c    = 1'b0;
      addr_c   = '0;
      wrdata_c = '0;
      wren_c   = 1'b0;

      unique case (state_q)
         IDLE: begin
            rdy_c = live_q;
            if (live_q && bus.en) begin
               i_d    = '0;
               j_d    = '0;
               kidx_d = '0;
               key_d  = bus.key;
`ifdef KSA_INIT_PASS_EN
               state_d = INIT_WR;
`else
               state_d = RD_I;
`endif
            end
         end
`ifdef KSA_INIT_PASS_EN
         INIT_WR: begin
            addr_c   = i_q;
            wrdata_c = i_q;
            wren_c   = 1'b1;
            if (i_q == LAST_IDX) begin
               i_d     = '0;
               state_d = RD_I;
            end else begin
               i_d = i_q + 8'd1;
            end
         end
`endif
         RD_I: begin
            addr_c  = i_q;
            state_d = CALC_J;
         end
         CALC_J: begin
            si_d    = bus.s_rddata;
            j_d     = jn;
            addr_c  = jn;
            state_d = WR_I;
         end
         WR_I: begin
            // Read data now holds old S[j] from the CALC_J access.
            addr_c   = i_q;
            wrdata_c = bus.s_rddata;
            wren_c   = 1'b1;
            state_d  = WR_J;
         end
         WR_J: begin
            addr_c   = j_q;
            wrdata_c = si_q;
            wren_c   = 1'b1;
            if (i_q == LAST_IDX) begin
               state_d = IDLE;
            end else begin
               i_d     = i_q + 8'd1;
               kidx_d  = (kidx_q == KIDX_LAST) ? 2'd0 : kidx_q + 2'd1;
               state_d = RD_I;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         i_q     <= '0;
         j_q     <= '0;
         kidx_q  <= '0;
         si_q    <= '0;
         key_q   <= '0;
         live_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         kidx_q  <= kidx_d;
         si_q    <= si_d;
         key_q   <= key_d;
         live_q  <= 1'b1;
      end
   end

   assign bus.rdy      = rdy_c;
   assign bus.s_addr   = addr_c;
   assign bus.s_wrdata = wrdata_c;
   assign bus.s_wren   = wren_c;
endmodule

// File: tb/tb_ksa.sv
// Bench for ksa: S memory model, ARC4 KSA reference trace, per-cycle bus compare.
module tb_ksa;
   typedef struct packed {
      logic [7:0] a;
      logic [7:0] d;
   } wr_t;
   typedef logic [7:0] sarr_t [256];

`ifdef KSA_INIT_PASS_EN
   localparam int LAT = 1280;
   localparam bit INIT_PASS = 1'b1;
`else
   localparam int LAT = 1024;
   localparam bit INIT_PASS = 1'b0;
`endif

   logic  clk;
   logic  rst_n;
   ksa_if bus ();

   sarr_t      mem;
   logic [7:0] rd_q;
   wr_t        exp_q[$];
   int         total;
   int         bad;

   ksa dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port synchronous S memory with one-cycle read latency.
   always @(posedge clk) begin
      if (bus.s_wren) mem[bus.s_addr] <= bus.s_wrdata;
      rd_q <= mem[bus.s_addr];
   end
   assign bus.s_rddata = rd_q;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference ARC4 key schedule producing the expected S write sequence.
   task automatic model_ksa(input logic [23:0] k, input sarr_t s_in,
                            output wr_t tr[$], output sarr_t s_out);
      sarr_t      s;
      logic [7:0] j, t, kb;
      s = s_in;
      j = 8'd0;
      tr.delete();
      for (int i = 0; i < 256; i++) begin
         kb = 8'(k >> (8 * (2 - (i % 3))));
         j  = j + s[i] + kb;
         t  = s[i];
         tr.push_back('{a: 8'(i), d: s[j]});
         tr.push_back('{a: j, d: t});
         s[i] = s[j];
         s[j] = t;
      end
      s_out = s;
   endtask

   // Write trace and idle-output check on every cycle out of reset.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.s_wren) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_write", {16'd0, bus.s_addr, bus.s_wrdata}, 32'hFFFF_FFFF);
            end else begin
               wr_t w;
               w = exp_q.pop_front();
               chk("write_trace", {16'd0, bus.s_addr, bus.s_wrdata}, {16'd0, w});
            end
         end
         if (bus.rdy) chk("idle_outputs", {15'd0, bus.s_wren, bus.s_addr, bus.s_wrdata}, 32'd0);
      end
   end

   task automatic run(input logic [23:0] k, input bit fresh, input bit perturb, input int abort_at);
      sarr_t s0, sf;
      wr_t   tr[$];
      int    cnt;
      int    nmis;
      if (fresh) begin
         for (int a = 0; a < 256; a++) mem[a] <= INIT_PASS ? 8'hAA : 8'(a);
         @(negedge clk);
      end
      for (int a = 0; a < 256; a++) s0[a] = INIT_PASS ? 8'(a) : mem[a];
      model_ksa(k, s0, tr, sf);
      exp_q.delete();
      if (INIT_PASS) for (int c = 0; c < 256; c++) exp_q.push_back('{a: 8'(c), d: 8'(c)});
      foreach (tr[n]) exp_q.push_back(tr[n]);

      bus.key = k;
      bus.en  = 1'b1;
      @(negedge clk);
      bus.en = 1'b0;
      cnt = 0;
      while (cnt < LAT + 20) begin
         if (bus.rdy) break;
         cnt++;
         if (abort_at != 0 && cnt == abort_at) begin
            #1 rst_n = 1'b0;
            #1 chk("abort_rdy_wren", {30'd0, bus.rdy, bus.s_wren}, 32'd0);
            chk("abort_addr", {24'd0, bus.s_addr}, 32'd0);
            exp_q.delete();
            bus.en = 1'b0;
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            #1 chk("release_rdy_low", {31'd0, bus.rdy}, 32'd0);
            @(negedge clk);
            chk("release_rdy_high", {31'd0, bus.rdy}, 32'd1);
            return;
         end
         if (perturb && cnt < LAT - 16) begin
            bus.en  = 1'($urandom);
            bus.key = 24'($urandom);
         end else begin
            bus.en = 1'b0;
         end
         @(negedge clk);
      end
      chk("busy_cycles", 32'(cnt), 32'(LAT));
      chk("trace_remaining", 32'(exp_q.size()), 32'd0);
      nmis = 0;
      for (int a = 0; a < 256; a++) if (mem[a] !== sf[a]) nmis++;
      chk("final_s", 32'(nmis), 32'd0);
   endtask

   initial begin
      sarr_t id_s, sf;
      wr_t   tr[$];
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.en  = 1'b0;
      bus.key = 24'd0;
      for (int a = 0; a < 256; a++) id_s[a] = 8'(a);

      // Hand-computed anchors for the reference model.
      model_ksa(24'h000000, id_s, tr, sf);
      chk("model_k0_w0", 32'(tr[0]), 32'h0000);
      chk("model_k0_w3", 32'(tr[3]), 32'h0101);
      chk("model_k0_w4", 32'(tr[4]), 32'h0203);
      chk("model_k0_w5", 32'(tr[5]), 32'h0302);
      model_ksa(24'h035F3C, id_s, tr, sf);
      chk("model_kA_w0", 32'(tr[0]), 32'h0003);
      chk("model_kA_w1", 32'(tr[1]), 32'h0300);
      chk("model_kA_w2", 32'(tr[2]), 32'h0163);
      chk("model_kA_w3", 32'(tr[3]), 32'h6301);
      model_ksa(24'hFFFFFF, id_s, tr, sf);
      chk("model_kF_w0", 32'(tr[0]), 32'h00FF);
      chk("model_kF_w1", 32'(tr[1]), 32'hFF00);

      #3;
      chk("reset_outputs", {15'd0, bus.rdy, bus.s_wren, bus.s_addr, bus.s_wrdata}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("first_release_rdy_low", {31'd0, bus.rdy}, 32'd0);
      @(negedge clk);
      chk("first_release_rdy_high", {31'd0, bus.rdy}, 32'd1);

      run(24'h000000, 1'b1, 1'b0, 0);
      run(24'h035F3C, 1'b1, 1'b0, 0);
      run(24'hFFFFFF, 1'b1, 1'b0, 0);
      for (int r = 0; r < 3; r++) run(24'($urandom), 1'b1, 1'b1, 0);
      run(24'($urandom), 1'b1, 1'b1, 500);
      run(24'($urandom), 1'b0, 1'b0, 0);
      run(24'($urandom), 1'b0, 1'b1, 0);

      repeat (4) @(negedge clk);
      chk("no_stray_writes", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ksa.md
Name: ksa

Overview:
- Implements the ARC4 key-scheduling pass over the shared 256x8 S memory.
- Assumes S already holds S[i]=i from the init stage.
- Permutes S using the 24-bit key, then hands off to the PRGA stage, which consumes the scheduled S.
- Uses the same en/rdy handshake and single-port S-memory interface as the neighbouring stages.

Parameters:
- KEY_BYTES, 3, number of key bytes cycled (fixed at 3 for a 24-bit key; other values unsupported).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  start request; honoured only while rdy=1.
- rdy  output  1  high when idle and able to accept en.
- key  input  24  key; byte0=key[23:16], byte1=key[15:8], byte2=key[7:0].
- s_addr  output  8  S memory address.
- s_rddata  input  8  S read data; valid the cycle after s_addr is presented with s_wren=0.
- s_wrdata  output  8  S write data.
- s_wren  output  1  S write enable.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, i=0, j=0, kidx=0, si=0, key_q=0.
  - Outputs during reset: rdy=0, s_addr=0, s_wrdata=0, s_wren=0.
  - First cycle after release: rdy=1.
- Reset mid-operation aborts immediately. S contents are left partially permuted; no recovery write occurs.
- Handshake:
  - en sampled at a rising edge with state=IDLE starts a run; key is captured into key_q at that edge.
  - rdy drops the following cycle.
  - en and key changes while busy are ignored.
  - en held high at completion starts a new run on the first IDLE edge.
- Per-index loop, 4 cycles per i, one S access per cycle:
  - IDLE: rdy=1, s_wren=0. On en: i=0, j=0, kidx=0, go RD_I.
  - RD_I: s_addr=i, s_wren=0. Go CALC_J.
  - CALC_J: si<=s_rddata. jn = j + s_rddata + key_q byte[kidx], all mod 256 (8-bit wrap). j<=jn, s_addr=jn, s_wren=0. Go WR_I.
  - WR_I: s_addr=i, s_wrdata=s_rddata (old S[j]), s_wren=1. Go WR_J.
  - WR_J: s_addr=j, s_wrdata=si, s_wren=1.
    - If i==255, go IDLE.
    - Else i<=i+1, kidx<=(kidx==2)?0:kidx+1, go RD_I.
- kidx is a 0..2 wrap counter; no divider.
- i==j: the two writes are WR_I: S[i]=S[i], then WR_J: S[i]=si. S is unchanged, as required.
- Latency: rdy is low for exactly 1024 cycles (256 iterations x 4) after the accepting edge. rdy=1 again in cycle 1025.
- s_wren is high only in WR_I and WR_J. s_addr and s_wrdata are 0 in IDLE.
- Outputs are combinational from state and registers; no output register stage.

Optional Feature:
- Macro: KSA_INIT_PASS_EN.
- Defined:
  - The block also performs the init pass. An INIT_WR state precedes RD_I and writes s_addr=c, s_wrdata=c, s_wren=1 for c=0..255 (256 cycles).
  - The key-scheduling loop then starts with i=0, j=0.
  - rdy low for 1280 cycles per run.
  - The separate init stage is not needed.
- Undefined: INIT_WR is absent; behaviour is exactly as above.

Test Plan:
- Reset: hold rst_n=0 asynchronously mid-cycle -> rdy=0, s_wren=0 immediately. Release -> rdy=1 next edge.
- key=0x000000 with S preloaded identity, pulse en:
  - Iterations i=0,1: writes (0,0),(0,0),(1,1),(1,1), i.e. self-swaps.
  - i=2: j=3, writes S[2]=3 then S[3]=2.
  - rdy returns after 1024 cycles.
  - Final S matches the C model.
- key=0x03 0x5F 0x3C, S identity:
  - i=0: j=0x03, writes S[0]=3, S[3]=0.
  - i=1: j=0x03+1+0x5F=0x63.
  - Full 256-entry S matches the golden ARC4 KSA model.
- 8-bit wrap: key=0xFFFFFF on identity S -> j arithmetic wraps mod 256 (i=0 gives j=0xFF). Final S matches the model.
- Busy robustness: change key and toggle en mid-run -> no effect on the write trace. Assert rst_n=0 at cycle 500 -> state IDLE, no writes after reset edge, new run restarts from i=0.
- KSA_INIT_PASS_EN defined, S preloaded with 0xAA garbage, key=0x000000 -> first 256 writes are S[c]=c, then the same trace as scenario 2. rdy low 1280 cycles.
